irq_pending_latch: RTL and testbench
====================================

// Module: irq_pending_latch
// PURPOSE
//   Captures N interrupt request lines into a sticky pending register with per-line edge/level
//   mode and an enable mask. Drives the masked pending vector straight into the 8-input priority
//   encoder downstream. Consumes the encoder's index back as an acknowledge to clear the serviced bit.
// PARAMETERS
//   N    8  number of request lines; the encoder input width
//   IDW  3  acknowledge index width, clog2(N)
// PORTS
//   clk        in   1    clock, all state on rising edge
//   rst        in   1    synchronous reset, active-high
//   irq_in     in   N    raw request lines
//   edge_mode  in   N    per line: 1 = rising-edge capture, 0 = level capture
//   mask_wr    in   1    load mask_data into the mask register this cycle
//   mask_data  in   N    new mask; bit=1 enables the line
//   ack        in   1    clear the pending bit selected by ack_id
//   ack_id     in   IDW  index of the serviced line (encoder out)
//   ovf_clr    in   1    clear all overflow flags
//   pend_out   out  N    pend_q & mask_q, combinational from registers; feeds encoder in
//   any_pend   out  1    |pend_out
//   pend_q     out  N    raw pending register
//   mask_q     out  N    mask register
//   ovf_q      out  N    sticky overflow flags
// BEHAVIOUR
//   - Reset: pend_q=0, mask_q=0 (all lines disabled), ovf_q=0, irq_prev=0, sync flops=0.
//     Outputs therefore reset to pend_out=0 and any_pend=0.
//   - irq_s is irq_in, or the synchronised copy when IRQ_SYNC_EN is defined.
//     irq_prev <= irq_s every cycle, including in cycles where rst is deasserted.
//   - Edge detect: rise = irq_s & ~irq_prev. A line already high when rst drops is captured as an edge
//     on the first active cycle.
//   - Set condition per line: set = edge_mode ? rise : irq_s.
//   - Clear condition: clr = onehot(ack_id) when ack=1 and ack_id<N. Otherwise clr=0.
//     An ack with ack_id>=N is ignored.
//   - Pending update: pend_q <= (pend_q & ~clr) | set. When set and clr hit the same bit together,
//     set wins and the request is never lost.
//   - Acking a bit that is not pending has no effect.
//   - ack clears the raw bit regardless of the mask.
//   - Level mode: a line still held high re-pends on the cycle after its ack.
//   - Masking: a masked line still latches into pend_q. It appears on pend_out the cycle after
//     mask_wr enables it.
//   - mask_q <= mask_data on mask_wr, visible the next cycle.
//   - Overflow: ovf_q[i] <= 1 when edge_mode[i] & rise[i] & pend_q[i] & ~clr[i]. This is an edge
//     arriving on a bit that is already pending and is not being acked.
//   - ovf_q is sticky. ovf_clr zeroes all flags. A new overflow in the same cycle as ovf_clr wins.
//   - Overflow never fires in level mode.
//   - Latency, irq_in rising to pend_q/pend_out: 1 cycle without sync, 3 cycles with IRQ_SYNC_EN.
//   - Latency, ack to cleared bit: 1 cycle.
//   - Changing edge_mode at runtime: irq_prev keeps tracking. The new mode applies from the next set
//     evaluation, and existing pending bits are kept.
//   - rst asserted mid-operation returns every register to its reset value on the next edge,
//     overriding all other inputs.
// CONFIGURATION
//   IRQ_SYNC_EN defined:
//     - irq_in passes through a 2-flop synchroniser per line before edge detection.
//     - Adds 2 cycles of capture latency.
//     - A pulse shorter than 1 clk may be missed.
//   IRQ_SYNC_EN undefined:
//     - irq_in is used directly.
//     - The integrator guarantees irq_in is synchronous to clk.
// TESTING  (N=8, IRQ_SYNC_EN undefined unless noted)
//   1. rst=1 for 2 cycles with irq_in=8'hFF -> pend_q=0, mask_q=0, ovf_q=0, any_pend=0.
//   2. mask_data=8'hFF, mask_wr; edge_mode=8'hFF; pulse irq_in[5] for 1 cycle ->
//      next cycle pend_out=8'h20, any_pend=1.
//      ack=1, ack_id=5 -> pend_out=8'h00 the following cycle.
//   3. edge_mode=0; hold irq_in[2]=1; ack ack_id=2 ->
//      pend_q[2] reads 1 again the cycle after the clear; ovf_q stays 0.
//   4. Edge line 3 pending; second rise on line 3 without ack -> ovf_q=8'h08, pend_q[3]=1.
//      ovf_clr -> ovf_q=0.
//      Rise on line 3 in the same cycle as ack_id=3 -> pend_q[3]=1, ovf_q=0.
//   5. mask_q=8'h00; pulse irq_in[7] -> pend_q=8'h80, pend_out=0.
//      mask_wr with 8'h80 -> pend_out=8'h80 one cycle later.
//      ack with ack_id=3'd7 while ack_id>=N is impossible at N=8; use N=6, ack_id=7 -> no change.
//   6. IRQ_SYNC_EN defined: rise on irq_in[0] at cycle t -> pend_q[0]=1 first visible at t+3.
//      rst asserted mid-sequence -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/irq_pending_latch.sv
// Sticky interrupt pending latch with per-line edge/level capture, enable mask and overflow flags.
// Define IRQ_SYNC_EN to put a 2-flop synchroniser on every irq_in line ahead of edge detection.
module irq_pending_latch #(
  parameter int unsigned N   = 8,
  parameter int unsigned IDW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   irq_in,
  input  logic [N-1:0]   edge_mode,
  input  logic           mask_wr,
  input  logic [N-1:0]   mask_data,
  input  logic           ack,
  input  logic [IDW-1:0] ack_id,
  input  logic           ovf_clr,
  output logic [N-1:0]   pend_out,
  output logic           any_pend,
  output logic [N-1:0]   pend_q,
  output logic [N-1:0]   mask_q,
  output logic [N-1:0]   ovf_q
);

  localparam logic [IDW:0] ACK_LIMIT = (IDW+1)'(N);

  logic [N-1:0] irq_s;
  logic [N-1:0] irq_prev;
  logic [N-1:0] rise;
  logic [N-1:0] set;
  logic [N-1:0] clr;
  logic [N-1:0] ovf_set;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  // Two-stage synchroniser for asynchronous request lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = irq_in;
`endif

  // Set/clear/overflow terms; an out-of-range ack index clears nothing
  always_comb begin
    rise    = irq_s & ~irq_prev;
    set     = (edge_mode & rise) | (~edge_mode & irq_s);
    clr     = '0;
    if (ack && ({1'b0, ack_id} < ACK_LIMIT)) begin
      clr = N'(1) << ack_id;
    end
    ovf_set = edge_mode & rise & pend_q & ~clr;
  end

  // Set is OR-ed after the clear so a simultaneous request is never lost
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      ovf_q    <= '0;
    end else begin
      irq_prev <= irq_s;
      pend_q   <= (pend_q & ~clr) | set;
      if (mask_wr) begin
        mask_q <= mask_data;
      end
      ovf_q    <= (ovf_clr ? '0 : ovf_q) | ovf_set;
    end
  end

  assign pend_out = pend_q & mask_q;
  assign any_pend = |pend_out;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: directed scenarios plus randomized traffic
// compared against a per-line behavioural model.
module tb_irq_pending_latch;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] edge_mode;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       ack;
  logic [2:0] ack_id;
  logic       ovf_clr;
  logic [7:0] pend_out, pend_q, mask_q, ovf_q;
  logic       any_pend;
  logic [5:0] pend_out6, pend_q6, mask_q6, ovf_q6;
  logic       any_pend6;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  logic [7:0] m_pend, m_mask, m_ovf, m_prev, m_s1, m_s2;

  always #5 clk = ~clk;

  irq_pending_latch #(.N(8), .IDW(3)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .edge_mode(edge_mode),
    .mask_wr(mask_wr), .mask_data(mask_data), .ack(ack), .ack_id(ack_id),
    .ovf_clr(ovf_clr), .pend_out(pend_out), .any_pend(any_pend),
    .pend_q(pend_q), .mask_q(mask_q), .ovf_q(ovf_q)
  );

  irq_pending_latch #(.N(6), .IDW(3)) dut6 (
    .clk(clk), .rst(rst), .irq_in(irq_in[5:0]), .edge_mode(edge_mode[5:0]),
    .mask_wr(mask_wr), .mask_data(mask_data[5:0]), .ack(ack), .ack_id(ack_id),
    .ovf_clr(ovf_clr), .pend_out(pend_out6), .any_pend(any_pend6),
    .pend_q(pend_q6), .mask_q(mask_q6), .ovf_q(ovf_q6)
  );

  task automatic idle();
    rst = 1'b0; irq_in = '0; mask_wr = 1'b0; mask_data = '0;
    ack = 1'b0; ack_id = '0; ovf_clr = 1'b0;
  endtask

  // Evaluate the rules line by line, then advance one clock and sample just after the edge
  task automatic tick();
    logic [7:0] s, np, no;
    bit r, st, cl;
`ifdef IRQ_SYNC_EN
    s = m_s2;
`else
    s = irq_in;
`endif
    np = m_pend;
    no = ovf_clr ? 8'h00 : m_ovf;
    for (int i = 0; i < 8; i++) begin
      r  = s[i] && !m_prev[i];
      st = edge_mode[i] ? r : s[i];
      cl = ack && (int'(ack_id) == i);
      if (cl) np[i] = 1'b0;
      if (st) np[i] = 1'b1;
      if (edge_mode[i] && r && m_pend[i] && !cl) no[i] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_pend = '0; m_mask = '0; m_ovf = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    end else begin
      m_pend = np;
      m_ovf  = no;
      if (mask_wr) m_mask = mask_data;
      m_prev = s;
      m_s2   = m_s1;
      m_s1   = irq_in;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; irq_in = 8'hFF; edge_mode = 8'hFF; mask_wr = 1'b1; mask_data = 8'hFF;
    ticks(2);
    tests++; if (pend_q !== 8'h00) begin fails++; $display("FAIL reset_pend_q got %h want 00", pend_q); end
    tests++; if (mask_q !== 8'h00) begin fails++; $display("FAIL reset_mask_q got %h want 00", mask_q); end
    tests++; if (ovf_q !== 8'h00) begin fails++; $display("FAIL reset_ovf_q got %h want 00", ovf_q); end
    tests++; if (any_pend !== 1'b0) begin fails++; $display("FAIL reset_any_pend got %b want 0", any_pend); end
    tests++; if (pend_out !== 8'h00) begin fails++; $display("FAIL reset_pend_out got %h want 00", pend_out); end
  endtask

  task automatic test_edge_ack();
    idle();
    edge_mode = 8'hFF; mask_wr = 1'b1; mask_data = 8'hFF;
    tick();
    idle();
    irq_in = 8'h20;
    tick();
    irq_in = 8'h00;
    ticks(LAT - 1);
    tests++; if (pend_out !== 8'h20) begin fails++; $display("FAIL edge_capture pend_out got %h want 20", pend_out); end
    tests++; if (any_pend !== 1'b1) begin fails++; $display("FAIL edge_any_pend got %b want 1", any_pend); end
    ack = 1'b1; ack_id = 3'd5;
    tick();
    idle();
    tests++; if (pend_out !== 8'h00) begin fails++; $display("FAIL edge_ack_clear pend_out got %h want 00", pend_out); end
  endtask

  task automatic test_level_reack();
    idle();
    edge_mode = 8'h00; irq_in = 8'h04;
    ticks(LAT);
    tests++; if (pend_q[2] !== 1'b1) begin fails++; $display("FAIL level_capture pend_q got %h want bit2 set", pend_q); end
    ack = 1'b1; ack_id = 3'd2;
    tick();
    ack = 1'b0;
    tick();
    tests++; if (pend_q[2] !== 1'b1) begin fails++; $display("FAIL level_repend pend_q got %h want bit2 set", pend_q); end
    tests++; if (ovf_q !== 8'h00) begin fails++; $display("FAIL level_no_ovf ovf_q got %h want 00", ovf_q); end
    irq_in = 8'h00;
    ticks(LAT);
    ack = 1'b1; ack_id = 3'd2;
    tick();
    idle();
    tests++; if (pend_q !== m_pend) begin fails++; $display("FAIL level_release pend_q got %h want %h", pend_q, m_pend); end
  endtask

  task automatic test_overflow();
    idle();
    edge_mode = 8'hFF; irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    ticks(LAT);
    irq_in = 8'h08;
    tick();
    irq_in = 8'h00;
    ticks(LAT - 1);
    tests++; if (ovf_q !== 8'h08) begin fails++; $display("FAIL ovf_set ovf_q got %h want 08", ovf_q); end
    tests++; if (pend_q[3] !== 1'b1) begin fails++; $display("FAIL ovf_pend pend_q got %h want bit3 set", pend_q); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tests++; if (ovf_q !== 8'h00) begin fails++; $display("FAIL ovf_clr ovf_q got %h want 00", ovf_q); end
    ticks(LAT);
    irq_in = 8'h08;
    ticks(LAT - 1);
    ack = 1'b1; ack_id = 3'd3;
    tick();
    idle();
    tests++; if (pend_q[3] !== 1'b1) begin fails++; $display("FAIL set_beats_ack pend_q got %h want bit3 set", pend_q); end
    tests++; if (ovf_q !== 8'h00) begin fails++; $display("FAIL ack_no_ovf ovf_q got %h want 00", ovf_q); end
  endtask

  task automatic test_mask();
    idle();
    rst = 1'b1;
    tick();
    idle();
    edge_mode = 8'hFF; irq_in = 8'h80;
    tick();
    irq_in = 8'h00;
    ticks(LAT - 1);
    tests++; if (pend_q !== 8'h80) begin fails++; $display("FAIL masked_latch pend_q got %h want 80", pend_q); end
    tests++; if (pend_out !== 8'h00) begin fails++; $display("FAIL masked_hidden pend_out got %h want 00", pend_out); end
    mask_wr = 1'b1; mask_data = 8'h80;
    tick();
    idle();
    tests++; if (pend_out !== 8'h80) begin fails++; $display("FAIL unmask pend_out got %h want 80", pend_out); end
  endtask

  task automatic test_ack_range();
    idle();
    rst = 1'b1;
    tick();
    idle();
    edge_mode = 8'hFF; mask_wr = 1'b1; mask_data = 8'hFF; irq_in = 8'h01;
    tick();
    idle();
    ticks(LAT - 1);
    tests++; if (pend_q6 !== 6'h01) begin fails++; $display("FAIL n6_capture pend_q got %h want 01", pend_q6); end
    ack = 1'b1; ack_id = 3'd7;
    tick();
    tests++; if (pend_q6 !== 6'h01) begin fails++; $display("FAIL n6_ack7_ignored pend_q got %h want 01", pend_q6); end
    ack_id = 3'd6;
    tick();
    tests++; if (pend_q6 !== 6'h01) begin fails++; $display("FAIL n6_ack6_ignored pend_q got %h want 01", pend_q6); end
    ack_id = 3'd0;
    tick();
    idle();
    tests++; if (pend_q6 !== 6'h00) begin fails++; $display("FAIL n6_ack0 pend_q got %h want 00", pend_q6); end
  endtask

  task automatic test_latency();
    int lat;
    idle();
    rst = 1'b1;
    tick();
    idle();
    edge_mode = 8'hFF;
    ticks(3);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    lat = 1;
    while (pend_q[0] !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    tests++; if (lat != LAT) begin fails++; $display("FAIL capture_latency got %0d want %0d", lat, LAT); end
    irq_in = 8'h5A; mask_wr = 1'b1; mask_data = 8'hFF;
    ticks(4);
    irq_in = 8'hA5; ovf_clr = 1'b0; rst = 1'b1;
    tick();
    idle();
    tests++; if ({pend_q, mask_q, ovf_q, pend_out, any_pend} !== 33'd0)
      begin fails++; $display("FAIL mid_reset pend=%h mask=%h ovf=%h out=%h any=%b want all 0", pend_q, mask_q, ovf_q, pend_out, any_pend); end
  endtask

  task automatic test_random();
    logic [7:0] exp_out;
    idle();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 80) == 0);
      irq_in    = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 20) == 0) edge_mode = 8'($urandom);
      mask_wr   = ($urandom_range(0, 5) == 0);
      mask_data = 8'($urandom);
      ack       = ($urandom_range(0, 1) == 0);
      ack_id    = 3'($urandom);
      ovf_clr   = ($urandom_range(0, 9) == 0);
      tick();
      exp_out = m_pend & m_mask;
      tests++; if (pend_q !== m_pend) begin fails++; $display("FAIL rand_pend_q c=%0d got %h want %h", c, pend_q, m_pend); end
      tests++; if (mask_q !== m_mask) begin fails++; $display("FAIL rand_mask_q c=%0d got %h want %h", c, mask_q, m_mask); end
      tests++; if (ovf_q !== m_ovf) begin fails++; $display("FAIL rand_ovf_q c=%0d got %h want %h", c, ovf_q, m_ovf); end
      tests++; if (pend_out !== exp_out) begin fails++; $display("FAIL rand_pend_out c=%0d got %h want %h", c, pend_out, exp_out); end
      tests++; if (any_pend !== (exp_out != 8'h00)) begin fails++; $display("FAIL rand_any_pend c=%0d got %b want %b", c, any_pend, exp_out != 8'h00); end
    end
    idle();
  endtask

  initial begin
    m_pend = '0; m_mask = '0; m_ovf = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    edge_mode = '0;
    idle();
    test_reset();
    test_edge_ack();
    test_level_reack();
    test_overflow();
    test_mask();
    test_ack_range();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
